// File: rtl/rom_scan_pkg.sv
// rtl/rom_scan_pkg.sv - shared state encoding and default sizes for the ROM max-scan sequencer
package rom_scan_pkg;

    localparam int DEF_DEPTH  = 512;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/rom_scan_ctrl_max_tracker.sv
// rtl/rom_scan_ctrl_max_tracker.sv - running maximum with first-load and strict-greater update
module max_tracker #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              vld,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] next_value,
    output logic [ADDR_W-1:0] next_index
);

    logic [DATA_W-1:0] cur_value;
    logic [ADDR_W-1:0] cur_index;
    logic              take;

    // Index 0 seeds the scan; later entries need a strictly larger value so ties keep the lower index.
    assign take = vld && ((idx == '0) || (data > cur_value));

    // The next-state view lets the sequencer publish a result that includes the entry being compared now.
    always_comb begin
        next_value = cur_value;
        next_index = cur_index;
        if (take) begin
            next_value = data;
            next_index = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cur_value <= '0;
            cur_index <= '0;
        end else begin
            cur_value <= next_value;
            cur_index <= next_index;
        end
    end

endmodule

// File: rtl/rom_scan_ctrl.sv
// rtl/rom_scan_ctrl.sv - sequencer that scans a synchronous ROM and publishes its max value and index
module rom_scan_ctrl
    import rom_scan_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_value,
    output logic [ADDR_W-1:0] max_index
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic              scan_go;
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] trk_value;
    logic [ADDR_W-1:0] trk_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (rom_addr == LAST_ADDR) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = cont ? S_SCAN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign scan_go = (state_nxt == S_SCAN) && (state != S_SCAN);
    assign rom_en  = (state == S_SCAN);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // Address parks on the last entry after a scan and only rewinds when a new scan begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else if (scan_go) begin
            rom_addr <= '0;
        end else if (rom_en && (rom_addr != LAST_ADDR)) begin
            rom_addr <= rom_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else begin
            rd_vld <= rom_en;
            rd_idx <= rom_addr;
        end
    end

    max_tracker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_max_tracker (
        .clk        (clk),
        .rst        (rst),
        .clr        (scan_go),
        .vld        (rd_vld),
        .idx        (rd_idx),
        .data       (rom_data),
        .next_value (trk_value),
        .next_index (trk_index)
    );

    // Leaving DRAIN the final entry is still in flight, so capture the tracker's next view.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_value <= '0;
            max_index <= '0;
        end else if (state == S_DRAIN) begin
            max_value <= trk_value;
            max_index <= trk_index;
        end
    end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb/tb_rom_scan_ctrl.sv - self-checking bench for rom_scan_ctrl with a DEPTH=8 behavioural ROM
module tb_rom_scan_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] max_value;
    logic [ADDR_W-1:0] max_index;

    logic [DATA_W-1:0] rom_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    rom_scan_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .max_value (max_value),
        .max_index (max_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the maximum over the whole ROM, then the first index holding it.
    task automatic ref_max(output logic [DATA_W-1:0] v, output logic [ADDR_W-1:0] i);
        v = '0;
        i = '0;
        for (int k = 0; k < DEPTH; k++) if (rom_mem[k] > v) v = rom_mem[k];
        for (int k = DEPTH - 1; k >= 0; k--) if (rom_mem[k] == v) i = ADDR_W'(k);
    endtask

    task automatic scan_once(output int done_cyc, output int n_done, output bit held_ok);
        logic [DATA_W-1:0] hv;
        logic [ADDR_W-1:0] hi;
        hv = max_value;
        hi = max_index;
        done_cyc = 0;
        n_done = 0;
        held_ok = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= DEPTH + 4; c++) begin
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end else if (n_done == 0 && (max_value !== hv || max_index !== hi)) begin
                held_ok = 1'b0;
            end
            if (c < DEPTH + 4) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cont = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({rom_en, rom_addr, busy, done, max_value, max_index} !== '0) begin
                $display("FAIL reset_state: got en=%0d addr=%0d busy=%0d done=%0d max=%0d idx=%0d expected all 0",
                         rom_en, rom_addr, busy, done, max_value, max_index);
                n_fail++;
            end
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] vals [DEPTH] = '{3, 7, 2, 9, 9, 1, 0, 4};
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = vals[k];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n_checks++;
            if (rom_en !== (c <= DEPTH) || rom_addr !== ADDR_W'((c <= DEPTH) ? c - 1 : DEPTH - 1)) begin
                $display("FAIL basic_addr cycle %0d: got en=%0d addr=%0d", c, rom_en, rom_addr);
                n_fail++;
            end
            n_checks++;
            if (done !== (c == DEPTH + 2) || busy !== (c <= DEPTH + 2)) begin
                $display("FAIL basic_done_busy cycle %0d: got done=%0d busy=%0d", c, done, busy);
                n_fail++;
            end
            n_checks++;
            if (c >= DEPTH + 2 && (max_value !== 16'd9 || max_index !== 3'd3)) begin
                $display("FAIL basic_result cycle %0d: got %0d/%0d expected 9/3", c, max_value, max_index);
                n_fail++;
            end else if (c < DEPTH + 2 && (max_value !== 16'd0 || max_index !== 3'd0)) begin
                $display("FAIL basic_hold cycle %0d: got %0d/%0d expected 0/0", c, max_value, max_index);
                n_fail++;
            end
            step();
        end
    endtask

    task automatic test_zero_and_last();
        int dc, nd;
        bit ok;
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = '0;
        scan_once(dc, nd, ok);
        n_checks++;
        if (max_value !== 16'd0 || max_index !== 3'd0 || dc != DEPTH + 2 || nd != 1) begin
            $display("FAIL all_zero: got %0d/%0d done_cyc=%0d n=%0d expected 0/0 at 10 once", max_value, max_index, dc, nd);
            n_fail++;
        end
        rom_mem[DEPTH-1] = 16'hFFFF;
        scan_once(dc, nd, ok);
        n_checks++;
        if (max_value !== 16'hFFFF || max_index !== 3'd7 || dc != DEPTH + 2 || nd != 1 || !ok) begin
            $display("FAIL last_entry: got %0d/%0d done_cyc=%0d n=%0d held=%0d expected 65535/7", max_value, max_index, dc, nd, ok);
            n_fail++;
        end
    endtask

    task automatic test_start_ignored();
        int nd;
        int dc;
        int guard;
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = DATA_W'(10 + k * 3);
        nd = 0;
        dc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 4);
            if (done) begin nd++; if (dc == 0) dc = c; end
            if (c > DEPTH + 2) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    $display("FAIL start_not_queued cycle %0d: got busy=%0d expected 0", c, busy);
                    n_fail++;
                end
            end
            step();
        end
        start = 1'b0;
        n_checks++;
        if (nd != 1 || dc != DEPTH + 2 || max_value !== 16'd31 || max_index !== 3'd7) begin
            $display("FAIL start_ignored: got n=%0d cyc=%0d res=%0d/%0d expected 1 at 10, 31/7", nd, dc, max_value, max_index);
            n_fail++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (rom_addr !== 3'd4 && guard < 20) begin step(); guard++; end
        n_checks++;
        if (guard >= 20) begin
            $display("FAIL abort_reach_addr4: got timeout expected addr 4");
            n_fail++;
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({rom_en, rom_addr, busy, done, max_value, max_index} !== '0) begin
            $display("FAIL abort_reset: got en=%0d addr=%0d busy=%0d done=%0d max=%0d idx=%0d expected all 0",
                     rom_en, rom_addr, busy, done, max_value, max_index);
            n_fail++;
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0/0", done, busy);
                n_fail++;
            end
        end
    endtask

    task automatic test_cont();
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = DATA_W'(k + 1);
        cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            n_checks++;
            if (done !== (c == 10 || c == 20)) begin
                $display("FAIL cont_done cycle %0d: got %0d expected %0d", c, done, (c == 10 || c == 20));
                n_fail++;
            end
            if (c >= 10 && c < 20) begin
                n_checks++;
                if (max_value !== 16'd8 || max_index !== 3'd7) begin
                    $display("FAIL cont_first cycle %0d: got %0d/%0d expected 8/7", c, max_value, max_index);
                    n_fail++;
                end
            end else if (c >= 20) begin
                n_checks++;
                if (max_value !== 16'd8 || max_index !== 3'd0 || busy !== (c == 20)) begin
                    $display("FAIL cont_second cycle %0d: got %0d/%0d busy=%0d expected 8/0 busy=%0d", c, max_value, max_index, busy, (c == 20));
                    n_fail++;
                end
            end
            if (c == 10) for (int k = 0; k < DEPTH; k++) rom_mem[k] = DATA_W'(DEPTH - k);
            if (c == 15) cont = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        int dcs [$];
        start = 1'b1;
        step();
        for (int c = 1; c <= 24; c++) begin
            if (done) dcs.push_back(c);
            if (c == 11) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    $display("FAIL b2b_idle_gap: got busy=%0d expected 0", busy);
                    n_fail++;
                end
            end
            if (c == 21) start = 1'b0;
            step();
        end
        n_checks++;
        if (dcs.size() != 2 || dcs[0] != 10 || dcs[1] != 21 || busy !== 1'b0) begin
            $display("FAIL b2b_done_cycles: got n=%0d first=%0d second=%0d busy=%0d expected 2 at 10,21 busy 0",
                     dcs.size(), (dcs.size() > 0) ? dcs[0] : -1, (dcs.size() > 1) ? dcs[1] : -1, busy);
            n_fail++;
        end
    endtask

    task automatic test_random();
        int dc, nd;
        bit ok;
        logic [DATA_W-1:0] ev;
        logic [ADDR_W-1:0] ei;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < DEPTH; k++)
                rom_mem[k] = (it % 2 == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
            ref_max(ev, ei);
            scan_once(dc, nd, ok);
            n_checks++;
            if (max_value !== ev || max_index !== ei) begin
                $display("FAIL random_result iter %0d: got %0d/%0d expected %0d/%0d", it, max_value, max_index, ev, ei);
                n_fail++;
            end
            n_checks++;
            if (dc != DEPTH + 2 || nd != 1 || !ok) begin
                $display("FAIL random_timing iter %0d: got done_cyc=%0d n=%0d held=%0d expected 10/1/1", it, dc, nd, ok);
                n_fail++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = '0;
        test_reset();
        test_basic();
        test_zero_and_last();
        test_start_ignored();
        test_cont();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
